qspi_xfer_ctrl: RTL and testbench

// Transaction sequencer behind the qspi byte-stream slave. Decodes the command byte and the
// 24-bit big-endian start address, then turns the byte stream into memory-bus accesses.

---
 rtl/qspi_xfer_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_qspi_xfer_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_xfer_ctrl.sv
// Generic FIFO: head and following entry are exposed so consumers can look one entry ahead.
// Latency: a push is visible at the head the cycle after it is written; flush empties in one cycle.
// Backpressure: push is ignored when full unless a pop happens in the same cycle; pop is ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic [WIDTH-1:0]       next_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + (PW+1)'(1);
            else if (!do_push && do_pop) count <= count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign next_dat = mem[rd_ptr + PW'(1)];
endmodule

// qspi_xfer_ctrl: decodes command + 24-bit address, then maps the qspi byte stream onto memory accesses.
// Latency: staged read byte shows on wr_data 1 cycle after push/pop; queued writes request memory 1 cycle later.
// Backpressure: one access outstanding, held until mem_ack; full write FIFO drops bytes, empty prefetch flags underrun.
module qspi_xfer_ctrl #(
    parameter int         ADDR_BITS  = 24,
    parameter logic [7:0] CMD_READ   = 8'h02,
    parameter logic [7:0] CMD_WRITE  = 8'h03,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 async_reset,
    input  logic                 start,
    input  logic [7:0]           rd_data,
    input  logic                 rd_valid,
    output logic [7:0]           wr_data,
    input  logic                 wr_valid,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic                 mem_ack,
    input  logic [7:0]           mem_rdata,
    output logic                 busy,
    output logic                 err_underrun,
    output logic                 err_overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, DISCARD} state_t;
    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [7:0]           dat;
    } wr_ent_t;

    state_t               state_q, state_d;
    logic                 is_rd_q;
    logic [1:0]           addr_byte_q;
    logic [ADDR_BITS-1:0] addr_cnt_q;
    logic                 rd_stale_q;

    wr_ent_t              wf_in_dat, wf_head, wf_next;
    logic [CW-1:0]        wf_count;
    logic                 wf_push, wf_pop, wf_full, wr_byte, overflow;

    logic [7:0]           pf_head, pf_next, wr_data_d;
    logic [CW-1:0]        pf_count;
    logic                 pf_push, pf_pop, rd_byte, underrun, rd_issue;

    assign wr_byte   = (state_q == WRITE) && rd_valid && !start;
    assign wf_pop    = mem_req && mem_ack && mem_we;
    assign wf_full   = (wf_count == DEPTH_C);
    assign wf_push   = wr_byte && (!wf_full || wf_pop);
    assign overflow  = wr_byte && wf_full && !wf_pop;
    assign wf_in_dat = {addr_cnt_q, rd_data};

    // A read acked after an abort (start) belongs to the old transaction and is dropped.
    assign rd_byte  = (state_q == READ) && wr_valid && !start;
    assign pf_pop   = rd_byte && (pf_count != '0);
    assign underrun = rd_byte && (pf_count == '0);
    assign pf_push  = mem_req && mem_ack && !mem_we && !rd_stale_q && !start;

    // Pending writes always win, so committed data lands before any new read.
    assign rd_issue = (state_q == READ) && !start && !mem_req && (wf_count == '0) && (pf_count < DEPTH_C);

    assign busy = ((state_q != IDLE) && (state_q != DISCARD)) || mem_req || (wf_count != '0);

    sync_fifo #(.WIDTH($bits(wr_ent_t)), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk      (clk),
        .rst      (async_reset),
        .flush    (1'b0),
        .push     (wf_push),
        .push_dat (wf_in_dat),
        .pop      (wf_pop),
        .head_dat (wf_head),
        .next_dat (wf_next),
        .count    (wf_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_pf_fifo (
        .clk      (clk),
        .rst      (async_reset),
        .flush    (start),
        .push     (pf_push),
        .push_dat (mem_rdata),
        .pop      (pf_pop),
        .head_dat (pf_head),
        .next_dat (pf_next),
        .count    (pf_count)
    );

    // wr_data tracks the prefetch head after this cycle's push/pop.
    always_comb begin
        wr_data_d = pf_head;
        if (start)
            wr_data_d = 8'hFF;
        else if (pf_pop && (pf_count > CW'(1)))
            wr_data_d = pf_next;
        else if (pf_pop || (pf_count == '0))
            wr_data_d = pf_push ? mem_rdata : 8'hFF;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = CMD;
        end else begin
            case (state_q)
                CMD: begin
                    if (rd_valid)
                        state_d = ((rd_data == CMD_READ) || (rd_data == CMD_WRITE)) ? ADDR : DISCARD;
                end
                ADDR: begin
                    if (rd_valid && (addr_byte_q == 2'd2))
                        state_d = is_rd_q ? READ : WRITE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            is_rd_q      <= 1'b0;
            addr_byte_q  <= 2'd0;
            addr_cnt_q   <= '0;
            rd_stale_q   <= 1'b0;
            wr_data      <= 8'hFF;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            err_underrun <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            wr_data      <= wr_data_d;
            err_underrun <= underrun;
            err_overflow <= overflow;

            if (start && mem_req && !mem_we && !mem_ack) rd_stale_q <= 1'b1;
            else if (mem_ack)                            rd_stale_q <= 1'b0;

            if (start) begin
                addr_byte_q <= 2'd0;
            end else if ((state_q == CMD) && rd_valid) begin
                is_rd_q <= (rd_data == CMD_READ);
            end else if ((state_q == ADDR) && rd_valid) begin
                addr_cnt_q  <= {addr_cnt_q[ADDR_BITS-9:0], rd_data};
                addr_byte_q <= addr_byte_q + 2'd1;
            end else if (wr_byte || rd_issue) begin
                addr_cnt_q <= addr_cnt_q + ADDR_BITS'(1);
            end

            if (mem_req) begin
                if (mem_ack) begin
                    // Chain straight into the next queued write without dropping mem_req.
                    if (mem_we && (wf_count > CW'(1))) begin
                        mem_addr  <= wf_next.addr;
                        mem_wdata <= wf_next.dat;
                    end else begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
            end else if (wf_count != '0) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= wf_head.addr;
                mem_wdata <= wf_head.dat;
            end else if (rd_issue) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= addr_cnt_q;
            end
        end
    end
endmodule

// File: tb/tb_qspi_xfer_ctrl.sv
// Bench for qspi_xfer_ctrl: scripted qspi transactions against a latency-programmable memory model.
module tb_qspi_xfer_ctrl;
    logic        clk = 1'b0;
    logic        async_reset;
    logic        start;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        err_underrun;
    logic        err_overflow;

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [7:0]  dat;
    } op_t;

    op_t        exp_ops[$];
    logic [7:0] exp_bytes[$];
    op_t        rsp_op;
    int total = 0;
    int bad = 0;
    int n_under = 0;
    int n_over = 0;
    int n_req = 0;
    int ack_lat = 1;
    int rsp_cnt = 0;

    always #5 clk = ~clk;

    qspi_xfer_ctrl dut (
        .clk          (clk),
        .async_reset  (async_reset),
        .start        (start),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .err_underrun (err_underrun),
        .err_overflow (err_overflow)
    );

    // Memory model: mem[a] = a[7:0]; acks the ack_lat-th cycle of each request and checks it against the scoreboard.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (err_underrun) n_under++;
            if (err_overflow) n_over++;
            if (mem_req) n_req++;
            if (async_reset) begin
                rsp_cnt = 0;
            end else if (mem_req) begin
                rsp_cnt++;
                if (rsp_cnt >= ack_lat) begin
                    rsp_cnt   = 0;
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr[7:0];
                    total++;
                    if (exp_ops.size() == 0) begin
                        bad++;
                        $display("FAIL mem_access unexpected we=%0b addr=%06h wdata=%02h, required none", mem_we, mem_addr, mem_wdata);
                    end else begin
                        rsp_op = exp_ops.pop_front();
                        if ((mem_we !== rsp_op.we) || (mem_addr !== rsp_op.addr) || (rsp_op.we && (mem_wdata !== rsp_op.dat))) begin
                            bad++;
                            $display("FAIL mem_access got we=%0b addr=%06h wdata=%02h, required we=%0b addr=%06h wdata=%02h",
                                     mem_we, mem_addr, mem_wdata, rsp_op.we, rsp_op.addr, rsp_op.dat);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        async_reset = 1'b1;
        start = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0; rd_data = 8'h00;
        repeat (2) @(negedge clk);
        async_reset = 1'b0;
        exp_ops.delete();
        exp_bytes.delete();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rd_data = b;
        rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
    endtask

    task automatic pulse_wr();
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic push_write(input logic [23:0] a, input logic [7:0] d);
        op_t o;
        o.we = 1'b1; o.addr = a; o.dat = d;
        exp_ops.push_back(o);
    endtask

    task automatic push_reads(input logic [23:0] base, input int n);
        op_t o;
        for (int i = 0; i < n; i++) begin
            o.we = 1'b0; o.addr = base + 24'(i); o.dat = 8'h00;
            exp_ops.push_back(o);
            exp_bytes.push_back(o.addr[7:0]);
        end
    endtask

    task automatic wait_data(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (wr_data !== 8'hFF) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        async_reset = 1'b1;
        start = 1'b0; rd_valid = 1'b0; wr_valid = 1'b0; rd_data = 8'h00;
        @(negedge clk);
        total++; if (wr_data !== 8'hFF) begin bad++; $display("FAIL reset_wr_data got %02h want ff", wr_data); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        total++; if (mem_addr !== 24'h0) begin bad++; $display("FAIL reset_mem_addr got %06h want 000000", mem_addr); end
        total++; if (mem_wdata !== 8'h00) begin bad++; $display("FAIL reset_mem_wdata got %02h want 00", mem_wdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if ({err_underrun, err_overflow} !== 2'b00) begin bad++; $display("FAIL reset_err got %b want 00", {err_underrun, err_overflow}); end
        async_reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({busy, mem_req, wr_data} !== {2'b00, 8'hFF}) begin bad++; $display("FAIL reset_idle got busy=%b req=%b wr_data=%02h want 0 0 ff", busy, mem_req, wr_data); end
    endtask

    task automatic test_read_stream();
        logic [7:0] e;
        int u0, o0;
        do_reset();
        ack_lat = 1;
        u0 = n_under; o0 = n_over;
        pulse_start();
        send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
        push_reads(24'h123456, 16);
        send_byte(8'h56);
        repeat (10) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL read_busy got %b want 1", busy); end
        for (int i = 0; i < 10; i++) begin
            e = exp_bytes.pop_front();
            total++;
            if (wr_data !== e) begin bad++; $display("FAIL read_byte%0d got %02h want %02h", i, wr_data, e); end
            pulse_wr();
            repeat (7) @(negedge clk);
        end
        total++; if ((n_under - u0) != 0) begin bad++; $display("FAIL read_underrun got %0d want 0", n_under - u0); end
        total++; if ((n_over - o0) != 0) begin bad++; $display("FAIL read_overflow got %0d want 0", n_over - o0); end
    endtask

    task automatic run_write(input string name, input logic [23:0] base, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input int n);
        logic [7:0] db [3];
        int o0;
        bit done;
        do_reset();
        ack_lat = 1;
        o0 = n_over;
        db[0] = d0; db[1] = d1; db[2] = d2;
        pulse_start();
        send_byte(8'h03); send_byte(base[23:16]); send_byte(base[15:8]); send_byte(base[7:0]);
        for (int i = 0; i < n; i++) begin
            push_write(base + 24'(i), db[i]);
            send_byte(db[i]);
        end
        done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (exp_ops.size() == 0) begin done = 1'b1; break; end
            @(negedge clk);
        end
        total++; if (!done) begin bad++; $display("FAIL %s_drain got %0d pending writes want 0", name, exp_ops.size()); end
        repeat (3) @(negedge clk);
        total++; if ({busy, mem_req} !== 2'b10) begin bad++; $display("FAIL %s_idle got busy=%b req=%b want 1 0", name, busy, mem_req); end
        total++; if ((n_over - o0) != 0) begin bad++; $display("FAIL %s_overflow got %0d want 0", name, n_over - o0); end
    endtask

    task automatic test_write_basic();
        run_write("write", 24'h000010, 8'hAA, 8'hBB, 8'hCC, 3);
    endtask

    task automatic test_write_wrap();
        run_write("wrap", 24'hFFFFFF, 8'h11, 8'h22, 8'h00, 2);
    endtask

    task automatic test_discard();
        int r0;
        do_reset();
        r0 = n_req;
        pulse_start();
        send_byte(8'h07);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL discard_busy got %b want 0", busy); end
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        repeat (10) @(negedge clk);
        total++; if ((n_req - r0) != 0) begin bad++; $display("FAIL discard_req got %0d req cycles want 0", n_req - r0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL discard_busy_end got %b want 0", busy); end
    endtask

    task automatic test_underrun();
        int u0, exp_under, got;
        logic [7:0] e;
        do_reset();
        ack_lat = 20;
        u0 = n_under; exp_under = 0; got = 0;
        pulse_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        push_reads(24'h000040, 16);
        send_byte(8'h40);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            if (wr_data === 8'hFF) begin
                exp_under++;
            end else begin
                e = exp_bytes.pop_front();
                got++;
                total++;
                if (wr_data !== e) begin bad++; $display("FAIL underrun_byte%0d got %02h want %02h", got, wr_data, e); end
            end
            pulse_wr();
            repeat (3) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        total++; if ((n_under - u0) != exp_under) begin bad++; $display("FAIL underrun_count got %0d want %0d", n_under - u0, exp_under); end
        total++; if ((exp_under < 8) || (got < 1)) begin bad++; $display("FAIL underrun_mix got %0d empty reads and %0d bytes want >=8 and >=1", exp_under, got); end
        ack_lat = 1;
    endtask

    task automatic test_overflow_restart();
        int o0, u0;
        bit ok;
        do_reset();
        ack_lat = 30;
        o0 = n_over; u0 = n_under;
        pulse_start();
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        push_write(24'h000100, 8'hA0);
        push_write(24'h000101, 8'hA1);
        send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        repeat (2) @(negedge clk);
        total++; if ((n_over - o0) != 2) begin bad++; $display("FAIL overflow_count got %0d want 2", n_over - o0); end
        pulse_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
        push_reads(24'h000200, 8);
        send_byte(8'h00);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy got %b want 1", busy); end
        for (int i = 0; i < 2; i++) begin
            wait_data(ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL restart_byte%0d timeout got ff want %02h", i, 8'(i));
            end else if (wr_data !== 8'(i)) begin
                bad++; $display("FAIL restart_byte%0d got %02h want %02h", i, wr_data, 8'(i));
            end
            pulse_wr();
        end
        total++; if ((n_under - u0) != 0) begin bad++; $display("FAIL restart_underrun got %0d want 0", n_under - u0); end
        ack_lat = 1;
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        do_reset();
        ack_lat = 20;
        pulse_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        push_reads(24'h000030, 4);
        send_byte(8'h30);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (mem_req === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        total++; if (!seen) begin bad++; $display("FAIL midreset_req_seen got 0 want 1"); end
        async_reset = 1'b1;
        #1;
        total++; if ({mem_req, busy, wr_data} !== {2'b00, 8'hFF}) begin bad++; $display("FAIL midreset_async got req=%b busy=%b wr_data=%02h want 0 0 ff", mem_req, busy, wr_data); end
        @(negedge clk);
        total++; if ({mem_req, busy, wr_data} !== {2'b00, 8'hFF}) begin bad++; $display("FAIL midreset_next got req=%b busy=%b wr_data=%02h want 0 0 ff", mem_req, busy, wr_data); end
        async_reset = 1'b0;
        ack_lat = 1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_read_stream();
        test_write_basic();
        test_write_wrap();
        test_discard();
        test_underrun();
        test_overflow_restart();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
